ad_chan_arb: RTL and testbench

//  Merges the three ADC channel streams (ad1/ad2/ad3: 24-bit sample + 1-cycle valid) into one

---
 rtl/ad_arb_pkg.sv | 17 +
 rtl/ad_arb_fifo.sv | 45 ++++
 rtl/ad_chan_arb.sv | 94 +++++++++
 tb/tb_ad_chan_arb.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad_arb_pkg.sv
// ad_arb_pkg: shared widths, fx register offsets and helpers for the ADC channel arbiter
package ad_arb_pkg;
    localparam int DW  = 24;
    localparam int NCH = 3;
    localparam logic [7:0] REG_EN   = 8'h00;
    localparam logic [7:0] REG_OVF0 = 8'h01;
    localparam logic [7:0] REG_OVF1 = 8'h02;
    localparam logic [7:0] REG_OVF2 = 8'h03;
    localparam logic [7:0] REG_CLR  = 8'h04;
    localparam logic [7:0] REG_STAT = 8'h05;
    function automatic logic fx_sel(input logic [15:0] addr, input logic [5:0] mod_id);
        return addr[15:8] == {2'b00, mod_id};
    endfunction
    function automatic logic [1:0] rr_next(input logic [1:0] c);
        return (c == 2'd2) ? 2'd0 : c + 2'd1;
    endfunction
endpackage

// File: rtl/ad_arb_fifo.sv
// ad_arb_fifo: single-clock holding FIFO with flush
//  push/wdata : write request (accepted when not full, or full with a same-cycle pop)
//  pop/rdata  : head word, removed on pop
//  flush      : empties the FIFO, overrides push/pop
//  full/empty : occupancy flags
module ad_arb_fifo #(
    parameter int DW     = 24,
    parameter int FDEPTH = 2
) (
    input  logic          clk_sys,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(FDEPTH);
    localparam logic [AW:0] NFULL = (AW+1)'(FDEPTH);
    logic [DW-1:0] mem [FDEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          wr, rd;
    assign full  = cnt == NFULL;
    assign empty = cnt == '0;
    assign rdata = mem[rp];
    assign wr    = push && (!full || pop);
    assign rd    = pop && !empty;
    always_ff @(posedge clk_sys) begin
        if (!rst_n || flush) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            wp  <= wr ? wp + 1'b1 : wp;
            rp  <= rd ? rp + 1'b1 : rp;
            cnt <= cnt + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
        end
    end
    always_ff @(posedge clk_sys) begin
        if (wr) mem[wp] <= wdata;
    end
endmodule

// File: rtl/ad_chan_arb.sv
// ad_chan_arb: round-robin merge of three ADC sample streams into one tagged stream
//  adN_data/adN_vld      : per-channel sample + 1-cycle strobe (ad1=ch0, ad2=ch1, ad3=ch2)
//  aq_data/aq_ch/aq_vld  : arbitrated sample, source channel, valid; aq_rdy accepts
//  fx_*/mod_id           : register bus (enable mask, overflow counters, status)
module ad_chan_arb
    import ad_arb_pkg::*;
#(
    parameter int FDEPTH = 2
) (
    input  logic          clk_sys,
    input  logic          rst_n,
    input  logic [DW-1:0] ad1_data,
    input  logic          ad1_vld,
    input  logic [DW-1:0] ad2_data,
    input  logic          ad2_vld,
    input  logic [DW-1:0] ad3_data,
    input  logic          ad3_vld,
    output logic [DW-1:0] aq_data,
    output logic [1:0]    aq_ch,
    output logic          aq_vld,
    input  logic          aq_rdy,
    input  logic [15:0]   fx_waddr,
    input  logic          fx_wr,
    input  logic [7:0]    fx_data,
    input  logic          fx_rd,
    input  logic [15:0]   fx_raddr,
    output logic [7:0]    fx_q,
    input  logic [5:0]    mod_id
);
    logic [DW-1:0]  in_data [NCH];
    logic [DW-1:0]  head    [NCH];
    logic [7:0]     ovf_cnt [NCH];
    logic [NCH-1:0] in_vld, push, pop, full, empty, req, clr, ovf_inc, en_mask;
    logic [1:0]     rr_last, grant, c1, c2;
    logic           load, wr_sel;
    logic [7:0]     rd_off, rd_val;
    assign in_data = '{ad1_data, ad2_data, ad3_data};
    assign in_vld  = {ad3_vld, ad2_vld, ad1_vld};
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        ad_arb_fifo #(.DW(DW), .FDEPTH(FDEPTH)) u_fifo (
            .clk_sys(clk_sys),
            .rst_n  (rst_n),
            .push   (push[i]),
            .pop    (pop[i]),
            .flush  (!en_mask[i]),
            .wdata  (in_data[i]),
            .rdata  (head[i]),
            .full   (full[i]),
            .empty  (empty[i])
        );
    end
    always_comb begin
        push    = in_vld & en_mask;
        // a disabled channel is flushed next cycle; masking its request keeps it from winning meanwhile
        req     = ~empty & en_mask;
        c1      = rr_next(rr_last);
        c2      = rr_next(c1);
        grant   = req[c1] ? c1 : req[c2] ? c2 : rr_last;
        load    = (!aq_vld || aq_rdy) && |req;
        pop     = load ? {{(NCH-1){1'b0}}, 1'b1} << grant : '0;
        ovf_inc = push & full & ~pop;
        wr_sel  = fx_wr && fx_sel(fx_waddr, mod_id);
        clr     = (wr_sel && fx_waddr[7:0] == REG_CLR) ? fx_data[NCH-1:0] : '0;
        rd_off  = fx_raddr[7:0];
        rd_val  = rd_off == REG_EN   ? {5'b0, en_mask} :
                  rd_off == REG_OVF0 ? ovf_cnt[0] :
                  rd_off == REG_OVF1 ? ovf_cnt[1] :
                  rd_off == REG_OVF2 ? ovf_cnt[2] :
                  rd_off == REG_STAT ? {2'b00, empty, aq_vld, 2'b00} : 8'h00;
    end
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            aq_vld  <= 1'b0;
            aq_data <= '0;
            aq_ch   <= 2'd0;
            rr_last <= 2'd2;
            en_mask <= '1;
            fx_q    <= 8'h00;
            for (int n = 0; n < NCH; n++) ovf_cnt[n] <= 8'h00;
        end else begin
            if (!aq_vld || aq_rdy) aq_vld <= |req;
            if (load) begin
                aq_data <= head[grant];
                aq_ch   <= grant;
                rr_last <= grant;
            end
            if (wr_sel && fx_waddr[7:0] == REG_EN) en_mask <= fx_data[NCH-1:0];
            for (int n = 0; n < NCH; n++)
                ovf_cnt[n] <= clr[n] ? 8'h00 :
                              (ovf_inc[n] && ovf_cnt[n] != 8'hFF) ? ovf_cnt[n] + 8'h01 : ovf_cnt[n];
            fx_q <= (fx_rd && fx_sel(fx_raddr, mod_id)) ? rd_val : 8'h00;
        end
    end
endmodule

// File: tb/tb_ad_chan_arb.sv
// tb_ad_chan_arb: directed and randomized checks of ad_chan_arb against a queue-level model
module tb_ad_chan_arb;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] d_in [3];
    logic        v_in [3];
    logic [23:0] aq_data;
    logic [1:0]  aq_ch;
    logic        aq_vld, aq_rdy;
    logic [15:0] fx_waddr, fx_raddr;
    logic        fx_wr, fx_rd;
    logic [7:0]  fx_data, fx_q;
    logic [5:0]  mod_id;
    int          n_pass = 0, n_tot = 0;
    bit          chk_en = 0;

    logic [23:0] mq [3][2];
    int          mc [3];
    logic [7:0]  m_ovf [3];
    logic [2:0]  m_mask, mp;
    logic        m_vld;
    logic [23:0] m_data;
    logic [1:0]  m_ch;
    int          m_rr, g, c;
    logic [7:0]  m_fxq, rq;

    always #5 clk = ~clk;

    ad_chan_arb dut (
        .clk_sys(clk), .rst_n(rst_n),
        .ad1_data(d_in[0]), .ad1_vld(v_in[0]),
        .ad2_data(d_in[1]), .ad2_vld(v_in[1]),
        .ad3_data(d_in[2]), .ad3_vld(v_in[2]),
        .aq_data(aq_data), .aq_ch(aq_ch), .aq_vld(aq_vld), .aq_rdy(aq_rdy),
        .fx_waddr(fx_waddr), .fx_wr(fx_wr), .fx_data(fx_data),
        .fx_rd(fx_rd), .fx_raddr(fx_raddr), .fx_q(fx_q), .mod_id(mod_id)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s got=%h expected=%h at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    // Reference model: per-channel queues of depth 2, stepped on each rising edge
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int n = 0; n < 3; n++) begin
                mc[n] = 0;
                m_ovf[n] = 8'h00;
            end
            m_vld = 0; m_data = 0; m_ch = 0; m_rr = 2; m_mask = 3'b111; m_fxq = 0;
        end else begin
            mp = m_mask;
            rq = 8'h00;
            if (fx_rd && fx_raddr[15:8] == {2'b00, mod_id}) begin
                case (fx_raddr[7:0])
                    8'h00: rq = {5'b0, m_mask};
                    8'h01: rq = m_ovf[0];
                    8'h02: rq = m_ovf[1];
                    8'h03: rq = m_ovf[2];
                    8'h05: rq = {2'b00, mc[2] == 0, mc[1] == 0, mc[0] == 0, m_vld, 2'b00};
                    default: rq = 8'h00;
                endcase
            end
            g = -1;
            for (int k = 1; k <= 3; k++) begin
                c = (m_rr + k) % 3;
                if (g < 0 && mp[c] && mc[c] > 0) g = c;
            end
            if (!m_vld || aq_rdy) begin
                m_vld = (g >= 0);
                if (g >= 0) begin
                    m_data = mq[g][0];
                    mq[g][0] = mq[g][1];
                    mc[g]--;
                    m_ch = 2'(g);
                    m_rr = g;
                end
            end
            for (int n = 0; n < 3; n++) begin
                if (!mp[n]) mc[n] = 0;
                else if (v_in[n]) begin
                    if (mc[n] < 2) begin
                        mq[n][mc[n]] = d_in[n];
                        mc[n]++;
                    end else if (m_ovf[n] != 8'hFF) m_ovf[n]++;
                end
            end
            if (fx_wr && fx_waddr[15:8] == {2'b00, mod_id}) begin
                if (fx_waddr[7:0] == 8'h00) m_mask = fx_data[2:0];
                if (fx_waddr[7:0] == 8'h04)
                    for (int n = 0; n < 3; n++) if (fx_data[n]) m_ovf[n] = 8'h00;
            end
            m_fxq = rq;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("aq_vld", aq_vld, m_vld);
            chk("aq_data", aq_data, m_data);
            chk("aq_ch", aq_ch, m_ch);
            chk("fx_q", fx_q, m_fxq);
        end
    end

    task automatic idle();
        for (int n = 0; n < 3; n++) v_in[n] = 0;
        fx_wr = 0;
        fx_rd = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        idle();
    endtask

    task automatic do_reset();
        rst_n = 0;
        cyc();
        rst_n = 1;
    endtask

    task automatic fx_write(input logic [7:0] off, input logic [7:0] d);
        fx_wr = 1; fx_waddr = {2'b00, mod_id, off}; fx_data = d;
        cyc();
    endtask

    task automatic fx_read(input string nm, input logic [7:0] off, input logic [7:0] exp);
        fx_rd = 1; fx_raddr = {2'b00, mod_id, off};
        cyc();
        chk(nm, fx_q, exp);
    endtask

    initial begin
        for (int n = 0; n < 3; n++) d_in[n] = 0;
        idle();
        aq_rdy = 0; mod_id = 6'h2A; fx_waddr = 0; fx_raddr = 0; fx_data = 0;
        rst_n = 0;
        repeat (3) cyc();
        rst_n = 1;
        chk_en = 1;
        chk("rst_vld", aq_vld, 0);
        chk("rst_data", aq_data, 0);
        chk("rst_ch", aq_ch, 0);

        aq_rdy = 1;
        d_in[1] = 24'h123456; v_in[1] = 1;
        cyc();
        chk("t1_early", aq_vld, 0);
        cyc();
        chk("t1_vld", aq_vld, 1);
        chk("t1_data", aq_data, 24'h123456);
        chk("t1_ch", aq_ch, 1);
        cyc();
        chk("t1_once", aq_vld, 0);

        do_reset();
        aq_rdy = 1;
        for (int r = 0; r < 2; r++) begin
            for (int n = 0; n < 3; n++) begin
                d_in[n] = 24'hA00000 + 24'(r * 16 + n);
                v_in[n] = 1;
            end
            cyc();
            for (int n = 0; n < 3; n++) begin
                cyc();
                chk("t2_vld", aq_vld, 1);
                chk("t2_ch", aq_ch, n);
                chk("t2_data", aq_data, 24'hA00000 + r * 16 + n);
            end
        end

        do_reset();
        aq_rdy = 0;
        for (int i = 0; i < 5; i++) begin
            d_in[0] = 24'(i); v_in[0] = 1;
            cyc();
        end
        fx_read("t3_ovf0", 8'h01, 8'h02);
        fx_read("t3_stat", 8'h05, 8'h34);
        fx_write(8'h04, 8'h01);
        fx_read("t3_clr", 8'h01, 8'h00);

        do_reset();
        aq_rdy = 0;
        repeat (300) begin
            d_in[2] = 24'h333333; v_in[2] = 1;
            cyc();
        end
        fx_read("t4_sat", 8'h03, 8'hFF);

        do_reset();
        aq_rdy = 1;
        fx_write(8'h00, 8'h05);
        fx_read("t5_mask", 8'h00, 8'h05);
        repeat (3) begin
            d_in[1] = 24'h0BAD00; v_in[1] = 1;
            cyc();
        end
        cyc();
        chk("t5_masked", aq_vld, 0);
        fx_read("t5_ovf1", 8'h02, 8'h00);
        fx_write(8'h00, 8'h07);
        aq_rdy = 0;
        for (int i = 0; i < 3; i++) begin
            d_in[0] = 24'hB00000 + 24'(i); v_in[0] = 1;
            cyc();
        end
        fx_write(8'h00, 8'h06);
        chk("t5_held_vld", aq_vld, 1);
        chk("t5_held_data", aq_data, 24'hB00000);
        aq_rdy = 1;
        repeat (5) begin
            cyc();
            chk("t5_flushed", aq_vld, 0);
        end
        fx_read("t5_stat", 8'h05, 8'h38);

        fx_write(8'h00, 8'h07);
        aq_rdy = 0;
        repeat (4) begin
            d_in[0] = 24'hC0FFEE; v_in[0] = 1;
            cyc();
        end
        chk("t6_busy", aq_vld, 1);
        fx_read("t6_ovf", 8'h01, 8'h01);
        fx_write(8'h00, 8'h02);
        rst_n = 0;
        cyc();
        chk("t6_rst_vld", aq_vld, 0);
        rst_n = 1;
        fx_read("t6_en", 8'h00, 8'h07);
        fx_read("t6_ovf0", 8'h01, 8'h00);
        fx_rd = 1; fx_raddr = {2'b01, mod_id, 8'h00};
        cyc();
        chk("t6_wrong_id", fx_q, 8'h00);

        for (int t = 0; t < 4000; t++) begin
            int dens;
            dens = (t / 500) % 4;
            rst_n = $urandom_range(0, 599) != 0;
            aq_rdy = $urandom_range(0, 3) != 0 || dens == 0;
            for (int n = 0; n < 3; n++) begin
                d_in[n] = 24'($urandom);
                v_in[n] = $urandom_range(0, dens + 1) == 0;
            end
            if ($urandom_range(0, 24) == 0) begin
                logic [7:0] off;
                off = 8'($urandom_range(0, 6));
                fx_wr = 1;
                fx_waddr = {($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00, mod_id, off};
                fx_data = (off == 8'h00 && $urandom_range(0, 2) != 0) ? 8'h07 : 8'($urandom);
            end
            if ($urandom_range(0, 3) == 0) begin
                fx_rd = 1;
                fx_raddr = {($urandom_range(0, 7) == 0) ? 2'b01 : 2'b00, mod_id, 8'($urandom_range(0, 7))};
            end
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
